// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared descriptor type, FSM states and defaults for the DMA dispatcher
package dma_pkg;

    localparam int DMA_DESC_FIFO_DEPTH = 16;
    localparam int DMA_ADDR_W_MAX      = 64;
    localparam int DMA_LEN_W_MAX       = 32;

    // Fields are sized for the widest supported configuration; narrower
    // instances zero-extend on push and use the low bits on output.
    typedef struct packed {
        logic [DMA_ADDR_W_MAX-1:0] src;
        logic [DMA_ADDR_W_MAX-1:0] dest;
        logic [DMA_LEN_W_MAX-1:0]  length;
    } t_dma_descriptor;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } t_dma_state;

endpackage

// File: rtl/dma_desc_fifo.sv
// rtl/dma_desc_fifo.sv - descriptor queue with push, pop, flush and occupancy count
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = DMA_DESC_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  t_dma_descriptor        push_data,
    input  logic                   pop,
    input  logic                   flush,
    output t_dma_descriptor        head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    t_dma_descriptor mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    // Flush takes priority over a simultaneous push or pop.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dma_dispatcher.sv
// rtl/dma_dispatcher.sv - queues copy descriptors and sequences one read then one write command each
module dma_dispatcher
    import dma_pkg::*;
#(
    parameter int DESC_FIFO_DEPTH = DMA_DESC_FIFO_DEPTH,
    parameter int ADDR_W          = 64,
    parameter int LEN_W           = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             desc_go,
    input  logic [ADDR_W-1:0]                desc_src_addr,
    input  logic [ADDR_W-1:0]                desc_dest_addr,
    input  logic [LEN_W-1:0]                 desc_length,
    input  logic                             ctrl_stop,
    input  logic                             ctrl_flush,
    output logic                             rd_cmd_valid,
    input  logic                             rd_cmd_ready,
    output logic [ADDR_W-1:0]                rd_cmd_addr,
    output logic [LEN_W-1:0]                 rd_cmd_len,
    input  logic                             rd_done,
    output logic                             wr_cmd_valid,
    input  logic                             wr_cmd_ready,
    output logic [ADDR_W-1:0]                wr_cmd_addr,
    output logic [LEN_W-1:0]                 wr_cmd_len,
    input  logic                             wr_done,
    output logic                             desc_full,
    output logic                             desc_empty,
    output logic [$clog2(DESC_FIFO_DEPTH):0] fill_level,
    output logic                             busy,
    output logic                             stopped,
    output logic                             overflow,
    output logic [15:0]                      seq_num
);

    t_dma_state      state_q, state_d;
    t_dma_descriptor hold_q, hold_d;
    t_dma_descriptor push_desc, head;
    logic [15:0]     seq_q, seq_d;
    logic            overflow_q, overflow_d;
    logic            pop;

    always_comb begin
        push_desc                    = '0;
        push_desc.src[ADDR_W-1:0]    = desc_src_addr;
        push_desc.dest[ADDR_W-1:0]   = desc_dest_addr;
        push_desc.length[LEN_W-1:0]  = desc_length;
    end

    dma_desc_fifo #(
        .DEPTH (DESC_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (desc_go),
        .push_data (push_desc),
        .pop       (pop),
        .flush     (ctrl_flush),
        .head      (head),
        .full      (desc_full),
        .empty     (desc_empty),
        .count     (fill_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        seq_d      = seq_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (desc_go & desc_full);
        case (state_q)
            IDLE: begin
                // No pop in a flush cycle, so a flushed head never goes in flight.
                if (!desc_empty && !ctrl_stop && !ctrl_flush) begin
                    pop = 1'b1;
                    if (head.length[LEN_W-1:0] == '0) begin
                        seq_d = seq_q + 16'd1;
                    end else begin
                        hold_d  = head;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ:  if (rd_cmd_ready) state_d = RD_WAIT;
            RD_WAIT: if (rd_done)      state_d = WR_REQ;
            WR_REQ:  if (wr_cmd_ready) state_d = WR_WAIT;
            WR_WAIT: begin
                if (wr_done) begin
                    seq_d   = seq_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_cmd_valid = (state_q == RD_REQ);
    assign wr_cmd_valid = (state_q == WR_REQ);
    assign rd_cmd_addr  = hold_q.src[ADDR_W-1:0];
    assign rd_cmd_len   = hold_q.length[LEN_W-1:0];
    assign wr_cmd_addr  = hold_q.dest[ADDR_W-1:0];
    assign wr_cmd_len   = hold_q.length[LEN_W-1:0];
    assign busy         = (state_q != IDLE);
    assign stopped      = (state_q == IDLE) && ctrl_stop && !reset;
    assign overflow     = overflow_q;
    assign seq_num      = seq_q;

endmodule

// File: tb/tb_dma_dispatcher.sv
// tb/tb_dma_dispatcher.sv - directed self-checking bench for dma_dispatcher
module tb_dma_dispatcher;

    logic        clk, reset;
    logic        desc_go;
    logic [63:0] desc_src_addr, desc_dest_addr;
    logic [31:0] desc_length;
    logic        ctrl_stop, ctrl_flush;
    logic        rd_cmd_valid, rd_cmd_ready, rd_done;
    logic [63:0] rd_cmd_addr;
    logic [31:0] rd_cmd_len;
    logic        wr_cmd_valid, wr_cmd_ready, wr_done;
    logic [63:0] wr_cmd_addr;
    logic [31:0] wr_cmd_len;
    logic        desc_full, desc_empty, busy, stopped, overflow;
    logic [4:0]  fill_level;
    logic [15:0] seq_num;

    int vectors = 0;
    int miscompares = 0;

    dma_dispatcher dut (
        .clk            (clk),
        .reset          (reset),
        .desc_go        (desc_go),
        .desc_src_addr  (desc_src_addr),
        .desc_dest_addr (desc_dest_addr),
        .desc_length    (desc_length),
        .ctrl_stop      (ctrl_stop),
        .ctrl_flush     (ctrl_flush),
        .rd_cmd_valid   (rd_cmd_valid),
        .rd_cmd_ready   (rd_cmd_ready),
        .rd_cmd_addr    (rd_cmd_addr),
        .rd_cmd_len     (rd_cmd_len),
        .rd_done        (rd_done),
        .wr_cmd_valid   (wr_cmd_valid),
        .wr_cmd_ready   (wr_cmd_ready),
        .wr_cmd_addr    (wr_cmd_addr),
        .wr_cmd_len     (wr_cmd_len),
        .wr_done        (wr_done),
        .desc_full      (desc_full),
        .desc_empty     (desc_empty),
        .fill_level     (fill_level),
        .busy           (busy),
        .stopped        (stopped),
        .overflow       (overflow),
        .seq_num        (seq_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1; desc_go = 1'b0; ctrl_stop = 1'b0; ctrl_flush = 1'b0;
        desc_src_addr = '0; desc_dest_addr = '0; desc_length = '0;
        rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1; rd_done = 1'b0; wr_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l);
        desc_src_addr = s; desc_dest_addr = d; desc_length = l; desc_go = 1'b1;
        @(posedge clk); #1;
        desc_go = 1'b0;
    endtask

    // Read phase: wait for the command, accept it, optionally flush while in RD_WAIT, then pulse rd_done.
    task automatic serve_rd(input bit flush_mid, output logic [63:0] a, output logic [31:0] l, output bit to);
        int n = 0;
        to = 1'b0; a = '0; l = '0;
        while (rd_cmd_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        if (rd_cmd_valid !== 1'b1) begin to = 1'b1; return; end
        a = rd_cmd_addr; l = rd_cmd_len;
        @(posedge clk); #1;
        if (flush_mid) begin ctrl_flush = 1'b1; @(posedge clk); #1; ctrl_flush = 1'b0; end
        repeat (3) @(posedge clk);
        #1 rd_done = 1'b1;
        @(posedge clk); #1;
        rd_done = 1'b0;
    endtask

    task automatic serve_wr(output logic [63:0] a, output logic [31:0] l, output bit to);
        int n = 0;
        to = 1'b0; a = '0; l = '0;
        while (wr_cmd_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        if (wr_cmd_valid !== 1'b1) begin to = 1'b1; return; end
        a = wr_cmd_addr; l = wr_cmd_len;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1 wr_done = 1'b1;
        @(posedge clk); #1;
        wr_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1; ctrl_stop = 1'b1;
        @(posedge clk); #1;
        vectors++; if (fill_level !== 5'd0 || desc_empty !== 1'b1 || desc_full !== 1'b0) begin miscompares++;
            $display("FAIL rst_queue: got fill=%0d empty=%b full=%b want 0/1/0", fill_level, desc_empty, desc_full); end
        vectors++; if ({rd_cmd_valid, wr_cmd_valid, busy, stopped, overflow} !== 5'b0) begin miscompares++;
            $display("FAIL rst_flags: got %b want 00000", {rd_cmd_valid, wr_cmd_valid, busy, stopped, overflow}); end
        vectors++; if (seq_num !== 16'd0) begin miscompares++;
            $display("FAIL rst_seq: got %0d want 0", seq_num); end
        vectors++; if ({rd_cmd_addr, wr_cmd_addr, rd_cmd_len, wr_cmd_len} !== '0) begin miscompares++;
            $display("FAIL rst_cmd: got %h %h %h %h want 0", rd_cmd_addr, wr_cmd_addr, rd_cmd_len, wr_cmd_len); end
        ctrl_stop = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [63:0] ra, wa; logic [31:0] rl, wl; bit t1, t2;
        do_reset();
        push(64'h1000, 64'h2000, 32'h40);
        serve_rd(1'b0, ra, rl, t1);
        serve_wr(wa, wl, t2);
        vectors++; if (t1 !== 1'b0 || t2 !== 1'b0) begin miscompares++;
            $display("FAIL single_timeout: got rd=%b wr=%b want 0/0", t1, t2); end
        vectors++; if (ra !== 64'h1000 || rl !== 32'h40) begin miscompares++;
            $display("FAIL single_rd: got %h/%h want 1000/40", ra, rl); end
        vectors++; if (wa !== 64'h2000 || wl !== 32'h40) begin miscompares++;
            $display("FAIL single_wr: got %h/%h want 2000/40", wa, wl); end
        vectors++; if (seq_num !== 16'd1) begin miscompares++;
            $display("FAIL single_seq: got %0d want 1", seq_num); end
        vectors++; if (busy !== 1'b0) begin miscompares++;
            $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        do_reset();
        ctrl_stop = 1'b1; rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(64'h100 * i, 64'h8000 + i, 32'h10);
        vectors++; if (desc_full !== 1'b1 || fill_level !== 5'd16 || overflow !== 1'b0) begin miscompares++;
            $display("FAIL ovf_after16: got full=%b fill=%0d ovf=%b want 1/16/0", desc_full, fill_level, overflow); end
        push(64'hDEAD, 64'hBEEF, 32'h10);
        vectors++; if (overflow !== 1'b1 || fill_level !== 5'd16) begin miscompares++;
            $display("FAIL ovf_after17: got ovf=%b fill=%0d want 1/16", overflow, fill_level); end
        vectors++; if (stopped !== 1'b1 || rd_cmd_valid !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL ovf_stopped: got stopped=%b rdv=%b busy=%b want 1/0/0", stopped, rd_cmd_valid, busy); end
        ctrl_flush = 1'b1; desc_go = 1'b1;
        @(posedge clk); #1;
        ctrl_flush = 1'b0; desc_go = 1'b0;
        vectors++; if (fill_level !== 5'd0 || desc_empty !== 1'b1 || desc_full !== 1'b0) begin miscompares++;
            $display("FAIL flush_go: got fill=%0d empty=%b full=%b want 0/1/0", fill_level, desc_empty, desc_full); end
        vectors++; if (overflow !== 1'b1) begin miscompares++;
            $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_stop();
        logic [63:0] ra, wa; logic [31:0] rl, wl; bit t1, t2;
        do_reset();
        ctrl_stop = 1'b1;
        for (int i = 1; i <= 3; i++) push(64'h1_0000 * i, 64'h2_0000 * i, 32'h20 * i);
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (rd_cmd_valid !== 1'b0 || stopped !== 1'b1 || fill_level !== 5'd3) begin miscompares++;
            $display("FAIL stop_hold: got rdv=%b stopped=%b fill=%0d want 0/1/3", rd_cmd_valid, stopped, fill_level); end
        ctrl_stop = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            serve_rd(1'b0, ra, rl, t1);
            serve_wr(wa, wl, t2);
            vectors++; if (t1 || t2 || ra !== 64'h1_0000 * i || wa !== 64'h2_0000 * i || wl !== 32'h20 * i) begin
                miscompares++;
                $display("FAIL stop_order%0d: got to=%b%b rd=%h wr=%h len=%h", i, t1, t2, ra, wa, wl);
            end
        end
        vectors++; if (seq_num !== 16'd3 || stopped !== 1'b0) begin miscompares++;
            $display("FAIL stop_seq: got seq=%0d stopped=%b want 3/0", seq_num, stopped); end
    endtask

    task automatic test_flush();
        logic [63:0] ra, wa; logic [31:0] rl, wl; bit t1, t2;
        do_reset();
        ctrl_stop = 1'b1;
        for (int i = 0; i < 5; i++) push(64'hA000 + i, 64'hB000 + i, 32'h8);
        ctrl_stop = 1'b0;
        serve_rd(1'b1, ra, rl, t1);
        vectors++; if (t1 || ra !== 64'hA000 || fill_level !== 5'd0 || busy !== 1'b1) begin miscompares++;
            $display("FAIL flush_mid: got to=%b rd=%h fill=%0d busy=%b want 0/a000/0/1", t1, ra, fill_level, busy); end
        serve_wr(wa, wl, t2);
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (t2 || wa !== 64'hB000 || seq_num !== 16'd1 || busy !== 1'b0 || desc_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_done: got to=%b wr=%h seq=%0d busy=%b empty=%b want 0/b000/1/0/1", t2, wa, seq_num, busy, desc_empty);
        end
    endtask

    task automatic test_zero_len();
        logic [63:0] ra, wa; logic [31:0] rl, wl; bit t1, t2;
        do_reset();
        ctrl_stop = 1'b1;
        push(64'h3000, 64'h4000, 32'h10);
        push(64'h5000, 64'h6000, 32'h0);
        push(64'h7000, 64'h9000, 32'h20);
        ctrl_stop = 1'b0;
        serve_rd(1'b0, ra, rl, t1);
        serve_wr(wa, wl, t2);
        vectors++; if (t1 || t2 || ra !== 64'h3000 || wa !== 64'h4000) begin miscompares++;
            $display("FAIL zlen_first: got to=%b%b rd=%h wr=%h want 3000/4000", t1, t2, ra, wa); end
        serve_rd(1'b0, ra, rl, t1);
        serve_wr(wa, wl, t2);
        vectors++; if (t1 || t2 || ra !== 64'h7000 || rl !== 32'h20 || wa !== 64'h9000) begin miscompares++;
            $display("FAIL zlen_skip: got to=%b%b rd=%h len=%h wr=%h want 7000/20/9000", t1, t2, ra, rl, wa); end
        vectors++; if (seq_num !== 16'd3 || busy !== 1'b0) begin miscompares++;
            $display("FAIL zlen_seq: got seq=%0d busy=%b want 3/0", seq_num, busy); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] ra; logic [31:0] rl; bit t1; int n = 0;
        do_reset();
        wr_cmd_ready = 1'b0;
        push(64'hC000, 64'hD000, 32'h30);
        serve_rd(1'b0, ra, rl, t1);
        while (wr_cmd_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        vectors++; if (t1 || wr_cmd_valid !== 1'b1 || wr_cmd_addr !== 64'hD000) begin miscompares++;
            $display("FAIL rmid_wrreq: got to=%b wrv=%b wr=%h want 0/1/d000", t1, wr_cmd_valid, wr_cmd_addr); end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++; if ({wr_cmd_valid, rd_cmd_valid, busy, stopped, overflow} !== 5'b0 || seq_num !== 16'd0) begin
            miscompares++;
            $display("FAIL rmid_flags: got %b seq=%0d want 00000/0", {wr_cmd_valid, rd_cmd_valid, busy, stopped, overflow}, seq_num);
        end
        vectors++; if (wr_cmd_addr !== '0 || wr_cmd_len !== '0 || fill_level !== 5'd0 || desc_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_cmd: got wr=%h len=%h fill=%0d empty=%b want 0/0/0/1", wr_cmd_addr, wr_cmd_len, fill_level, desc_empty);
        end
        reset = 1'b0; wr_cmd_ready = 1'b1;
        @(posedge clk); #1;
        wr_done = 1'b1;
        @(posedge clk); #1;
        wr_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (seq_num !== 16'd0 || busy !== 1'b0 || wr_cmd_valid !== 1'b0) begin miscompares++;
            $display("FAIL rmid_after: got seq=%0d busy=%b wrv=%b want 0/0/0", seq_num, busy, wr_cmd_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_stop();
        test_flush();
        test_zero_len();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
